// File: rtl/hilo_muldiv_ctrl.sv
// rtl/hilo_muldiv_ctrl.sv - HI/LO register owner and multiply/divide sequencer beside EX
module hilo_muldiv_ctrl #(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        op_valid,
  input  logic        flush,
  input  logic        is_mult,
  input  logic        is_multu,
  input  logic        is_mul,
  input  logic        is_div,
  input  logic        is_divu,
  input  logic        hi_wen,
  input  logic        lo_wen,
  input  logic        read_hi,
  input  logic        read_lo,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        stall,
  output logic        busy,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic [31:0] product_lo,
  output logic        product_valid
);

  typedef enum logic [1:0] {IDLE, MUL, MUL_GPR, DIV} state_t;

  localparam logic [5:0] MUL_LAST = 6'(MUL_LAT);
  localparam logic [5:0] DIV_LAST = 6'd32;

  state_t      state, state_nxt;
  logic [5:0]  cnt, cnt_nxt;

  logic        any_op, hazard, issue;
  logic        mul_last, gpr_last, div_last;

  // multiply operands, already extended to 33 bits at issue
  logic [32:0] mul_a, mul_b;
  logic [63:0] mul_ext_a, mul_ext_b, mul_prod;

  // restoring divider state: div_q shifts the dividend out and the quotient in
  logic [31:0] div_q, div_d, div_r, div_rs;
  logic        div_neg_q, div_neg_r, div_zero;
  logic [32:0] r_shift;
  logic        r_ge;
  logic [31:0] r_step, q_step, q_fix, r_fix;

  assign any_op = is_mult | is_multu | is_mul | is_div | is_divu |
                  hi_wen | lo_wen | read_hi | read_lo;
  assign busy   = (state != IDLE);
  assign hazard = op_valid & busy & any_op;
  // busy is zero in IDLE, so the hazard term can never block an IDLE issue
  assign issue  = op_valid & ~flush & (state == IDLE);

  assign mul_last = (state == MUL)     && (cnt == MUL_LAST);
  assign gpr_last = (state == MUL_GPR) && (cnt == MUL_LAST);
  assign div_last = (state == DIV)     && (cnt == DIV_LAST);

  // a held mul stalls only for itself; the hazard term would otherwise
  // keep it stalled through its own result cycle
  assign stall = (state == MUL_GPR) ? (cnt != MUL_LAST)
                                    : (hazard | (issue & is_mul));

  // 64-bit modular product of the sign-extended operands gives the exact
  // signed/unsigned 64-bit result
  assign mul_ext_a = {{31{mul_a[32]}}, mul_a};
  assign mul_ext_b = {{31{mul_b[32]}}, mul_b};
  assign mul_prod  = mul_ext_a * mul_ext_b;

  assign product_valid = gpr_last & ~flush;
  assign product_lo    = product_valid ? mul_prod[31:0] : 32'd0;

  // one restoring iteration; when the trial subtract succeeds the true
  // difference is below the divisor, so the low 32 bits are exact
  assign r_shift = {div_r, div_q[31]};
  assign r_ge    = (r_shift >= {1'b0, div_d});
  assign r_step  = r_ge ? (r_shift[31:0] - div_d) : r_shift[31:0];
  assign q_step  = {div_q[30:0], r_ge};
  assign q_fix   = div_neg_q ? (32'd0 - q_step) : q_step;
  assign r_fix   = div_neg_r ? (32'd0 - r_step) : r_step;

  // state and iteration counter register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= 6'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // next-state: counter starts at 1 in the first busy cycle
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (issue && (is_mult || is_multu)) begin
          state_nxt = MUL;
          cnt_nxt   = 6'd1;
        end else if (issue && is_mul) begin
          state_nxt = MUL_GPR;
          cnt_nxt   = 6'd1;
        end else if (issue && (is_div || is_divu)) begin
          state_nxt = DIV;
          cnt_nxt   = 6'd1;
        end
      end
      MUL: begin
        if (mul_last) begin
          state_nxt = IDLE;
          cnt_nxt   = 6'd0;
        end else begin
          cnt_nxt = cnt + 6'd1;
        end
      end
      MUL_GPR: begin
        if (flush || gpr_last) begin
          state_nxt = IDLE;
          cnt_nxt   = 6'd0;
        end else begin
          cnt_nxt = cnt + 6'd1;
        end
      end
      DIV: begin
        if (div_last) begin
          state_nxt = IDLE;
          cnt_nxt   = 6'd0;
        end else begin
          cnt_nxt = cnt + 6'd1;
        end
      end
    endcase
  end

  // multiply operand capture at issue
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mul_a <= 33'd0;
      mul_b <= 33'd0;
    end else if (issue && (is_mult || is_multu || is_mul)) begin
      mul_a <= {rs_data[31] & ~is_multu, rs_data};
      mul_b <= {rt_data[31] & ~is_multu, rt_data};
    end
  end

  // divider: latch magnitudes and signs at issue, then one bit per cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_q     <= 32'd0;
      div_d     <= 32'd0;
      div_r     <= 32'd0;
      div_rs    <= 32'd0;
      div_neg_q <= 1'b0;
      div_neg_r <= 1'b0;
      div_zero  <= 1'b0;
    end else if (issue && (is_div || is_divu)) begin
      div_q     <= (is_div && rs_data[31]) ? (32'd0 - rs_data) : rs_data;
      div_d     <= (is_div && rt_data[31]) ? (32'd0 - rt_data) : rt_data;
      div_r     <= 32'd0;
      div_rs    <= rs_data;
      div_neg_q <= is_div & (rs_data[31] ^ rt_data[31]);
      div_neg_r <= is_div & rs_data[31];
      div_zero  <= (rt_data == 32'd0);
    end else if (state == DIV) begin
      div_q <= q_step;
      div_r <= r_step;
    end
  end

  // HI/LO architectural registers; completions and mthi/mtlo never coincide
  // because moves only issue from IDLE
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_out <= 32'd0;
      lo_out <= 32'd0;
    end else if (mul_last) begin
      hi_out <= mul_prod[63:32];
      lo_out <= mul_prod[31:0];
    end else if (div_last) begin
      hi_out <= div_zero ? div_rs : r_fix;
      lo_out <= div_zero ? 32'hFFFF_FFFF : q_fix;
    end else if (issue) begin
      if (hi_wen) hi_out <= rs_data;
      if (lo_wen) lo_out <= rs_data;
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// tb/tb_hilo_muldiv_ctrl.sv - directed and randomized checks of hilo_muldiv_ctrl
module tb_hilo_muldiv_ctrl;
  localparam int MUL_LAT = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        op_valid, flush;
  logic        is_mult, is_multu, is_mul, is_div, is_divu;
  logic        hi_wen, lo_wen, read_hi, read_lo;
  logic [31:0] rs_data, rt_data;
  logic        stall, busy, product_valid;
  logic [31:0] hi_out, lo_out, product_lo;

  int          checks = 0;
  int          passed = 0;
  int          fails  = 0;
  logic [31:0] model_hi, model_lo;

  hilo_muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .resetn(resetn), .op_valid(op_valid), .flush(flush),
    .is_mult(is_mult), .is_multu(is_multu), .is_mul(is_mul),
    .is_div(is_div), .is_divu(is_divu), .hi_wen(hi_wen), .lo_wen(lo_wen),
    .read_hi(read_hi), .read_lo(read_lo), .rs_data(rs_data), .rt_data(rt_data),
    .stall(stall), .busy(busy), .hi_out(hi_out), .lo_out(lo_out),
    .product_lo(product_lo), .product_valid(product_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_in();
    op_valid = 0; flush = 0; is_mult = 0; is_multu = 0; is_mul = 0;
    is_div = 0; is_divu = 0; hi_wen = 0; lo_wen = 0; read_hi = 0; read_lo = 0;
    rs_data = 0; rt_data = 0;
  endtask

  function automatic logic [63:0] model_mul(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  task automatic model_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] q, output logic [31:0] r);
    longint la, lb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else begin
      if (sgn) begin
        la = longint'($signed(a));
        lb = longint'($signed(b));
      end else begin
        la = longint'({32'd0, a});
        lb = longint'({32'd0, b});
      end
      q = 32'(la / lb);
      r = 32'(la % lb);
    end
  endtask

  task automatic run_mult(input bit sgn, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [63:0] p;
    int n;
    p = model_mul(sgn, a, b);
    op_valid = 1; is_mult = sgn; is_multu = !sgn; rs_data = a; rt_data = b;
    #1 check({tag, " issue stall"}, 32'(stall), 32'd0);
    cyc();
    clear_in();
    n = 0;
    while (busy && n < 100) begin n++; cyc(); end
    check({tag, " busy cycles"}, 32'(n), 32'(MUL_LAT));
    check({tag, " hi"}, hi_out, p[63:32]);
    check({tag, " lo"}, lo_out, p[31:0]);
    model_hi = p[63:32];
    model_lo = p[31:0];
  endtask

  task automatic run_div(input bit sgn, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] q, r;
    int n;
    model_div(sgn, a, b, q, r);
    op_valid = 1; is_div = sgn; is_divu = !sgn; rs_data = a; rt_data = b;
    #1 check({tag, " issue stall"}, 32'(stall), 32'd0);
    cyc();
    clear_in();
    n = 0;
    while (busy && n < 100) begin n++; cyc(); end
    check({tag, " busy cycles"}, 32'(n), 32'd32);
    check({tag, " hi"}, hi_out, r);
    check({tag, " lo"}, lo_out, q);
    model_hi = r;
    model_lo = q;
  endtask

  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [63:0] p;
    int n;
    p = model_mul(1'b1, a, b);
    op_valid = 1; is_mul = 1; rs_data = a; rt_data = b;
    #1;
    n = 0;
    while (stall && n < 20) begin n++; cyc(); #1; end
    check({tag, " stall cycles"}, 32'(n), 32'(MUL_LAT));
    check({tag, " product_valid"}, 32'(product_valid), 32'd1);
    check({tag, " product_lo"}, product_lo, p[31:0]);
    cyc();
    clear_in();
    #1 check({tag, " not reissued"}, 32'(busy), 32'd0);
    check({tag, " pv drops"}, 32'(product_valid), 32'd0);
    check({tag, " hi kept"}, hi_out, model_hi);
    check({tag, " lo kept"}, lo_out, model_lo);
  endtask

  task automatic run_mt(input bit hi_sel, input logic [31:0] val, input bit fl, input string tag);
    op_valid = 1; hi_wen = hi_sel; lo_wen = !hi_sel; flush = fl; rs_data = val;
    #1 check({tag, " stall"}, 32'(stall), 32'd0);
    cyc();
    clear_in();
    if (!fl) begin
      if (hi_sel) model_hi = val;
      else model_lo = val;
    end
    check({tag, " hi"}, hi_out, model_hi);
    check({tag, " lo"}, lo_out, model_lo);
  endtask

  initial begin
    logic [31:0] q, r, a, b, x;
    int n;
    int unsigned op;

    clear_in();
    resetn = 0;
    model_hi = 0;
    model_lo = 0;
    @(negedge clk);
    cyc();
    check("reset hi", hi_out, 32'd0);
    check("reset lo", lo_out, 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset stall", 32'(stall), 32'd0);
    check("reset product_valid", 32'(product_valid), 32'd0);
    check("reset product_lo", product_lo, 32'd0);
    resetn = 1;
    cyc();

    run_mult(1'b1, 32'hFFFF_FFFF, 32'd2, "mult");
    check("mult hi const", hi_out, 32'hFFFF_FFFF);
    check("mult lo const", lo_out, 32'hFFFF_FFFE);
    run_mult(1'b0, 32'hFFFF_FFFF, 32'd2, "multu");
    check("multu hi const", hi_out, 32'h0000_0001);
    check("multu lo const", lo_out, 32'hFFFF_FFFE);

    // div -7/2 followed by mflo: the read stalls for the whole divide
    op_valid = 1; is_div = 1; rs_data = 32'hFFFF_FFF9; rt_data = 32'd2;
    #1 check("div7 issue stall", 32'(stall), 32'd0);
    cyc();
    clear_in();
    op_valid = 1; read_lo = 1;
    #1;
    n = 0;
    while (stall && n < 100) begin n++; cyc(); #1; end
    check("mflo stall cycles", 32'(n), 32'd32);
    check("mflo value", lo_out, 32'hFFFF_FFFD);
    check("div7 hi", hi_out, 32'hFFFF_FFFF);
    model_hi = 32'hFFFF_FFFF;
    model_lo = 32'hFFFF_FFFD;
    cyc();
    clear_in();

    run_div(1'b0, 32'h0000_1234, 32'd0, "divu by zero");
    check("divu0 lo const", lo_out, 32'hFFFF_FFFF);
    check("divu0 hi const", hi_out, 32'h0000_1234);
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div overflow");
    check("divovf lo const", lo_out, 32'h8000_0000);
    check("divovf hi const", hi_out, 32'd0);

    run_mul(32'd3, 32'hFFFF_FFFF, "mul");
    check("mul product const", model_mul(1'b1, 32'd3, 32'hFFFF_FFFF) == 64'hFFFF_FFFF_FFFF_FFFD ? 32'd1 : 32'd0, 32'd1);

    // mul aborted by a flush while in flight
    op_valid = 1; is_mul = 1; rs_data = 32'd5; rt_data = 32'd7;
    cyc();
    flush = 1;
    #1 check("mul abort pv", 32'(product_valid), 32'd0);
    cyc();
    clear_in();
    #1 check("mul abort idle", 32'(busy), 32'd0);
    check("mul abort pv after", 32'(product_valid), 32'd0);
    check("mul abort hi", hi_out, model_hi);
    check("mul abort lo", lo_out, model_lo);

    run_mt(1'b1, 32'hA5A5_A5A5, 1'b1, "mthi flushed");
    run_mt(1'b1, 32'hA5A5_A5A5, 1'b0, "mthi");
    check("mthi const", hi_out, 32'hA5A5_A5A5);

    // mtlo presented during a divide waits for it, then overwrites LO
    a = $urandom; b = $urandom | 32'd1; x = $urandom;
    model_div(1'b1, a, b, q, r);
    op_valid = 1; is_div = 1; rs_data = a; rt_data = b;
    cyc();
    clear_in();
    op_valid = 1; lo_wen = 1; rs_data = x;
    #1;
    n = 0;
    while (stall && n < 100) begin n++; cyc(); #1; end
    check("mtlo stall cycles", 32'(n), 32'd32);
    cyc();
    clear_in();
    check("mtlo after div lo", lo_out, x);
    check("mtlo after div hi", hi_out, r);
    model_hi = r;
    model_lo = x;

    // asynchronous reset in the middle of a divide
    op_valid = 1; is_divu = 1; rs_data = $urandom; rt_data = $urandom | 32'd1;
    cyc();
    clear_in();
    for (int i = 0; i < 9; i++) cyc();
    resetn = 0;
    #1;
    check("midreset hi", hi_out, 32'd0);
    check("midreset lo", lo_out, 32'd0);
    check("midreset busy", 32'(busy), 32'd0);
    check("midreset stall", 32'(stall), 32'd0);
    cyc();
    resetn = 1;
    model_hi = 0;
    model_lo = 0;
    cyc();
    run_mult(1'b1, $urandom, $urandom, "post reset mult");

    // randomized mix against the arithmetic model
    for (int i = 0; i < 30; i++) begin
      op = $urandom_range(0, 6);
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 7) == 0) b = 32'd0;
      if ($urandom_range(0, 9) == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      case (op)
        0: run_mult(1'b1, a, b, "rnd mult");
        1: run_mult(1'b0, a, b, "rnd multu");
        2: run_div(1'b1, a, b, "rnd div");
        3: run_div(1'b0, a, b, "rnd divu");
        4: run_mul(a, b, "rnd mul");
        5: run_mt(1'b1, a, 1'($urandom_range(0, 1)), "rnd mthi");
        default: run_mt(1'b0, a, 1'($urandom_range(0, 1)), "rnd mtlo");
      endcase
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
